// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the cache-to-physical-memory arbiter.
package pmem_arbiter_pkg;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT_I,
        ARB_GRANT_D
    } lc3b_arb_state;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/pmem_arbiter.sv
// Arbitrates the I-cache and D-cache onto one physical-memory port.
// D-side wins by default; a streak counter bounds how long I can be held off.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    lc3b_arb_state       state_q, state_d;
    logic [STREAK_W-1:0] d_streak_q, d_streak_d;
    logic                i_req, d_req;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            d_streak_q <= '0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        d_streak_d   = d_streak_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        // Read data is broadcast; only the resp pulse tells a client it is valid.
        i_pmem_rdata = pmem_rdata;
        d_pmem_rdata = pmem_rdata;

        unique case (state_q)
            ARB_IDLE: begin
                if (d_req && (!i_req || d_streak_q < STREAK_MAX)) begin
                    state_d = ARB_GRANT_D;
                end else if (i_req) begin
                    state_d = ARB_GRANT_I;
                end
            end
            ARB_GRANT_I: begin
                pmem_read    = i_pmem_read;
                pmem_write   = i_pmem_write;
                pmem_address = i_pmem_address;
                pmem_wdata   = i_pmem_wdata;
                i_pmem_resp  = pmem_resp;
                if (pmem_resp) begin
                    state_d    = ARB_IDLE;
                    d_streak_d = '0;
                end
            end
            ARB_GRANT_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                if (pmem_resp) begin
                    state_d = ARB_IDLE;
                    // Only count D wins that actually kept a waiting I-side out.
                    if (!i_req) begin
                        d_streak_d = '0;
                    end else if (d_streak_q < STREAK_MAX) begin
                        d_streak_d = d_streak_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    a_i_holds_req: assert property (@(posedge clk) disable iff (reset)
        (state_q == ARB_GRANT_I && !pmem_resp) |-> i_req);
    a_d_holds_req: assert property (@(posedge clk) disable iff (reset)
        (state_q == ARB_GRANT_D && !pmem_resp) |-> d_req);
    a_i_not_rw: assert property (@(posedge clk) disable iff (reset)
        !(i_pmem_read && i_pmem_write));
    a_d_not_rw: assert property (@(posedge clk) disable iff (reset)
        !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: grant order, streak limit, async reset, resp routing.
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic [15:0]   i_pmem_address, d_pmem_address, pmem_address;
    logic [127:0]  i_pmem_wdata, d_pmem_wdata, pmem_wdata;
    logic          i_pmem_resp, d_pmem_resp, pmem_read, pmem_write, pmem_resp;
    logic [127:0]  i_pmem_rdata, d_pmem_rdata, pmem_rdata;

    int total = 0;
    int bad   = 0;

    pmem_arbiter #(.MAX_D_STREAK(4), .ADDR_W(16), .LINE_W(128)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
        .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] wd_d;
        logic [127:0] wd_i;
        wd_d = {4{32'hDEAD_BEEF}};
        wd_i = {16{8'hA5}};

        reset = 1'b1;
        i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 0; pmem_rdata = '0;
        step(); step();
        check("rst_state", 128'(dut.state_q), 128'(ARB_IDLE));
        check("rst_streak", 128'(dut.d_streak_q), 128'd0);
        check("rst_pmem_read", 128'(pmem_read), 128'd0);
        check("rst_pmem_write", 128'(pmem_write), 128'd0);
        reset = 1'b0;

        // 1: D read, resp on fifth grant cycle
        step();
        d_pmem_read = 1; d_pmem_address = 16'h1230;
        step();
        check("t1_pmem_read", 128'(pmem_read), 128'd1);
        check("t1_addr", 128'(pmem_address), 128'h1230);
        for (int c = 0; c < 4; c++) begin
            check("t1_d_resp_wait", 128'(d_pmem_resp), 128'd0);
            check("t1_i_resp_wait", 128'(i_pmem_resp), 128'd0);
            step();
        end
        pmem_resp = 1; pmem_rdata = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        #1;
        check("t1_d_resp", 128'(d_pmem_resp), 128'd1);
        check("t1_i_resp", 128'(i_pmem_resp), 128'd0);
        check("t1_d_rdata", d_pmem_rdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        step();
        pmem_resp = 0; d_pmem_read = 0;
        #1;
        check("t1_d_resp_after", 128'(d_pmem_resp), 128'd0);
        check("t1_pmem_read_after", 128'(pmem_read), 128'd0);

        // 2: simultaneous I read and D write, D first
        i_pmem_read = 1; i_pmem_address = 16'h0040;
        d_pmem_write = 1; d_pmem_address = 16'h2000; d_pmem_wdata = wd_d;
        step();
        check("t2_d_write", 128'(pmem_write), 128'd1);
        check("t2_d_noread", 128'(pmem_read), 128'd0);
        check("t2_d_addr", 128'(pmem_address), 128'h2000);
        check("t2_d_wdata", pmem_wdata, wd_d);
        pmem_resp = 1; #1;
        check("t2_d_resp", 128'(d_pmem_resp), 128'd1);
        check("t2_i_resp_none", 128'(i_pmem_resp), 128'd0);
        step();
        pmem_resp = 0; d_pmem_write = 0;
        check("t2_gap_state", 128'(dut.state_q), 128'(ARB_IDLE));
        check("t2_gap_read", 128'(pmem_read), 128'd0);
        check("t2_streak", 128'(dut.d_streak_q), 128'd1);
        step();
        check("t2_i_read", 128'(pmem_read), 128'd1);
        check("t2_i_addr", 128'(pmem_address), 128'h0040);
        pmem_resp = 1; #1;
        check("t2_i_resp", 128'(i_pmem_resp), 128'd1);
        check("t2_d_resp_none", 128'(d_pmem_resp), 128'd0);
        step();
        pmem_resp = 0; i_pmem_read = 0;
        check("t2_streak_clr", 128'(dut.d_streak_q), 128'd0);

        // 3: D continuous with I waiting: four D grants, then I
        i_pmem_read = 1; i_pmem_address = 16'h0100;
        d_pmem_read = 1; d_pmem_address = 16'h0200;
        for (int g = 0; g < 5; g++) begin
            step();
            check($sformatf("t3_g%0d_addr", g), 128'(pmem_address),
                  (g < 4) ? 128'h0200 : 128'h0100);
            check($sformatf("t3_g%0d_streak", g), 128'(dut.d_streak_q), 128'(g));
            pmem_resp = 1; #1;
            check($sformatf("t3_g%0d_d_resp", g), 128'(d_pmem_resp), (g < 4) ? 128'd1 : 128'd0);
            check($sformatf("t3_g%0d_i_resp", g), 128'(i_pmem_resp), (g < 4) ? 128'd0 : 128'd1);
            step();
            pmem_resp = 0;
            check($sformatf("t3_g%0d_idle", g), 128'(dut.state_q), 128'(ARB_IDLE));
            if (g == 4) begin
                i_pmem_read = 0; d_pmem_read = 0;
            end
        end
        check("t3_streak_end", 128'(dut.d_streak_q), 128'd0);

        // 4: async reset in the middle of an I grant
        i_pmem_read = 1; i_pmem_address = 16'h0040;
        step();
        check("t4_pre_read", 128'(pmem_read), 128'd1);
        #2 reset = 1'b1;
        #1;
        check("t4_read_drop", 128'(pmem_read), 128'd0);
        check("t4_state", 128'(dut.state_q), 128'(ARB_IDLE));
        step();
        i_pmem_read = 0;
        step();
        reset = 1'b0;
        pmem_resp = 1; #1;
        check("t4_no_i_resp", 128'(i_pmem_resp), 128'd0);
        step();
        pmem_resp = 0;

        // 5: spurious pmem_resp in IDLE
        step();
        pmem_resp = 1; #1;
        check("t5_i_resp", 128'(i_pmem_resp), 128'd0);
        check("t5_d_resp", 128'(d_pmem_resp), 128'd0);
        step();
        pmem_resp = 0;
        check("t5_state", 128'(dut.state_q), 128'(ARB_IDLE));

        // 6: I writeback
        i_pmem_write = 1; i_pmem_address = 16'h3FF0; i_pmem_wdata = wd_i;
        step();
        check("t6_write", 128'(pmem_write), 128'd1);
        check("t6_addr", 128'(pmem_address), 128'h3FF0);
        check("t6_wdata", pmem_wdata, wd_i);
        check("t6_resp_wait", 128'(i_pmem_resp), 128'd0);
        step();
        pmem_resp = 1; #1;
        check("t6_resp", 128'(i_pmem_resp), 128'd1);
        step();
        pmem_resp = 0; i_pmem_write = 0;
        #1;
        check("t6_resp_once", 128'(i_pmem_resp), 128'd0);
        check("t6_write_off", 128'(pmem_write), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
